uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  RTL UART transmitter: accepts one parallel data word per valid/ready handshake and serializes it onto tx.
//  Frame is start bit, 5-8 data bits LSB-first, optional even/odd parity, then 1 or 2 stop bits.
//  Bit timing comes from an oversampled baud tick (divisor x oversampling rate).
//  Sits upstream of the UART RX monitor/receiver; produces the serial line the TX packet struct describes.
// PARAMETERS
//  DATA_WIDTH   8    max data bits per frame; dataType selects 5..DATA_WIDTH
//  DIV_WIDTH    16   width of baud divisor input
// PORTS
//  clk           in   1           system clock
//  reset         in   1           asynchronous, active-high reset
//  baudDivisor   in   DIV_WIDTH   clk cycles per oversample tick; 0 treated as 1
//  overSampling  in   5           ticks per bit: 16 or 13; any other value treated as 16
//  dataType      in   4           data bits per frame: 5..8; other values treated as 8
//  parityEnable  in   1           1 = parity bit inserted after data
//  parityType    in   1           0 = even, 1 = odd
//  stopBits      in   2           2 = two stop bits, any other value = one
//  txValid       in   1           upstream word valid
//  txData        in   DATA_WIDTH  word to send; bits above dataType ignored
//  txReady       out  1           block can accept a word
//  tx            out  1           serial line, idle high
//  busy          out  1           frame in progress
//  frameDone     out  1           1-cycle pulse on the cycle the last stop bit completes
// BEHAVIOUR
//  Reset (async, any state): tx=1, txReady=1, busy=0, frameDone=0, FSM=IDLE, all counters=0.
//  Accept: txValid&&txReady at a rising edge latches txData and all config inputs.
//   - Next cycle: tx=0 (START), txReady=0, busy=1.
//   - Config changes during a frame have no effect until the next accept.
//  Bit period: bitCycles = max(baudDivisor,1)*overSampling clk cycles.
//   - A divide counter generates a tick every max(baudDivisor,1) cycles.
//   - A tick counter advances the bit after overSampling ticks.
//   - Both counters restart at accept.
//  FSM: IDLE -> START -> DATA -> [PARITY if parityEnable] -> STOP1 -> [STOP2 if stopBits==2] -> IDLE.
//   - Each non-IDLE state holds tx for exactly one bitCycles period.
//  DATA: bit index 0..dataType-1; tx = latched data[index]; exits after index dataType-1.
//  PARITY: tx = XOR(data[dataType-1:0]) ^ parityType; even gives an even total count of ones.
//  STOP: tx=1.
//  Last stop bit end: frameDone=1 for one cycle, FSM=IDLE, busy=0, txReady=1 in the same cycle.
//   - A new accept in that cycle is legal: back-to-back frames, no idle gap, START follows STOP.
//  Frame length: (1 + dataType + parityEnable + stops) * bitCycles cycles, measured from first tx=0 to the frameDone cycle inclusive.
//  txReady is 0 for the whole frame; txValid with txReady=0 is ignored and txData is not sampled.
//  Reset mid-frame: tx returns to 1 immediately (async); the partial frame is discarded and no frameDone is issued.
// CONFIGURATION
//  UART_TX_ERR_INJ_EN defined:
//   - Adds inputs parityErrInj and framingErrInj, latched at accept.
//   - parityErrInj inverts the transmitted parity bit (no effect if parity is disabled).
//   - framingErrInj drives tx=0 during STOP1 (STOP2, if present, stays 1).
//   - frameDone still pulses.
//  UART_TX_ERR_INJ_EN undefined: no such ports; frames are always well-formed.
// TESTING
//  1. div=1, os=16, 8-bit, no parity, 1 stop, send 0xA5
//     -> tx = 0,1,0,1,0,0,1,0,1,1, each held 16 cycles; frameDone 160 cycles after first tx=0.
//  2. Same config, even parity, send 0xA5 -> parity bit 0.
//     Odd parity -> parity bit 1. Frame = 176 cycles.
//  3. 5-bit, 2 stop, div=2, os=13, send 0xFF
//     -> bits 0,1,1,1,1,1,1,1, each 26 cycles; upper 3 data bits are not sent.
//  4. txValid held high with 0x55 then 0x0F
//     -> second accepted in the frameDone cycle; its START follows STOP with no idle cycle.
//     -> txReady=0 throughout each frame.
//  5. reset asserted mid-DATA of 0x3C -> tx=1, busy=0, txReady=1 immediately, no frameDone.
//     -> after release, 0x81 is sent correctly.
//  6. With UART_TX_ERR_INJ_EN: parity on, parityErrInj=1, send 0xA5 (even)
//     -> parity bit 1.
//     -> framingErrInj=1 -> STOP1 sampled low.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmitter. One word per txValid/txReady handshake is
// serialized as start bit, 5..DATA_WIDTH data bits LSB-first, optional parity and
// one or two stop bits. Bit period = max(baudDivisor,1) * overSampling clk cycles.
// Optional feature macro: UART_TX_ERR_INJ_EN adds parity/framing error injection inputs.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIV_WIDTH-1:0]  baudDivisor,
    input  logic [4:0]            overSampling,
    input  logic [3:0]            dataType,
    input  logic                  parityEnable,
    input  logic                  parityType,
    input  logic [1:0]            stopBits,
    input  logic                  txValid,
    input  logic [DATA_WIDTH-1:0] txData,
`ifdef UART_TX_ERR_INJ_EN
    input  logic                  parityErrInj,
    input  logic                  framingErrInj,
`endif
    output logic                  txReady,
    output logic                  tx,
    output logic                  busy,
    output logic                  frameDone
);

    localparam int          IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [3:0]  MAX_BITS = 4'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    state_t                 state, state_nxt;

    // counters
    logic [DIV_WIDTH-1:0]   div_cnt, div_nxt;
    logic [4:0]             tick_cnt, tick_nxt;
    logic [IDX_W-1:0]       bit_idx, idx_nxt;

    // frame configuration captured at accept
    logic [DIV_WIDTH-1:0]   div_lat;
    logic [4:0]             os_lat;
    logic [3:0]             nbits;
    logic                   par_en, par_type, two_stop;
    logic [DATA_WIDTH-1:0]  data_lat;
    logic                   par_inj, frm_inj;

    // normalised incoming configuration
    logic [DIV_WIDTH-1:0]   div_in;
    logic [4:0]             os_in;
    logic [3:0]             nbits_in;
    logic [DATA_WIDTH-1:0]  data_in;

    logic                   tick, bit_end, last_bit, frame_end, accept, tx_nxt;

    assign tick     = (div_cnt == div_lat - DIV_WIDTH'(1));
    assign bit_end  = tick && (tick_cnt == os_lat - 5'd1);
    assign last_bit = (4'(bit_idx) == nbits - 4'd1);
    assign accept   = txValid && txReady;

    // Map out-of-range config to defaults; unused upper data bits are zeroed so
    // the parity reduction can cover the whole latched word.
    always_comb begin
        div_in   = (baudDivisor == '0) ? DIV_WIDTH'(1) : baudDivisor;
        os_in    = (overSampling == 5'd13) ? 5'd13 : 5'd16;
        nbits_in = (dataType >= 4'd5 && dataType <= MAX_BITS) ? dataType : MAX_BITS;
        data_in  = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            data_in[i] = txData[i] & (i < int'(nbits_in));
    end

    // Next state, counter updates and next line value; outputs follow from state.
    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        tick_nxt  = tick_cnt;
        idx_nxt   = bit_idx;
        frame_end = 1'b0;
        tx_nxt    = 1'b1;

        if (state != S_IDLE) begin
            div_nxt  = tick ? '0 : div_cnt + DIV_WIDTH'(1);
            tick_nxt = !tick ? tick_cnt : (bit_end ? 5'd0 : tick_cnt + 5'd1);
        end

        case (state)
            S_IDLE:   ;
            S_START:  if (bit_end) state_nxt = S_DATA;
            S_DATA:   if (bit_end) begin
                          if (last_bit) begin
                              idx_nxt   = '0;
                              state_nxt = par_en ? S_PARITY : S_STOP1;
                          end else begin
                              idx_nxt = bit_idx + IDX_W'(1);
                          end
                      end
            S_PARITY: if (bit_end) state_nxt = S_STOP1;
            S_STOP1:  if (bit_end) begin
                          if (two_stop) begin
                              state_nxt = S_STOP2;
                          end else begin
                              frame_end = 1'b1;
                              state_nxt = S_IDLE;
                          end
                      end
            S_STOP2:  if (bit_end) begin
                          frame_end = 1'b1;
                          state_nxt = S_IDLE;
                      end
            default:  state_nxt = S_IDLE;
        endcase

        // The last stop-bit cycle already counts as idle so a waiting word can
        // start immediately with no gap on the line.
        txReady   = (state == S_IDLE) || frame_end;
        busy      = (state != S_IDLE) && !frame_end;
        frameDone = frame_end;

        if (txValid && txReady) begin
            state_nxt = S_START;
            div_nxt   = '0;
            tick_nxt  = '0;
            idx_nxt   = '0;
        end

        case (state_nxt)
            S_START:  tx_nxt = 1'b0;
            S_DATA:   tx_nxt = data_lat[idx_nxt];
            S_PARITY: tx_nxt = ^data_lat ^ par_type ^ par_inj;
            S_STOP1:  tx_nxt = ~frm_inj;
            default:  tx_nxt = 1'b1;
        endcase
    end

    // State, counters and a registered tx so the line never glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_nxt;
            tick_cnt <= tick_nxt;
            bit_idx  <= idx_nxt;
            tx       <= tx_nxt;
        end
    end

    // Capture word and configuration at accept; held constant for the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_lat  <= DIV_WIDTH'(1);
            os_lat   <= 5'd16;
            nbits    <= MAX_BITS;
            par_en   <= 1'b0;
            par_type <= 1'b0;
            two_stop <= 1'b0;
            data_lat <= '0;
        end else if (accept) begin
            div_lat  <= div_in;
            os_lat   <= os_in;
            nbits    <= nbits_in;
            par_en   <= parityEnable;
            par_type <= parityType;
            two_stop <= (stopBits == 2'd2);
            data_lat <= data_in;
        end
    end

`ifdef UART_TX_ERR_INJ_EN
    // Error-injection controls, captured with the rest of the frame config.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_inj <= 1'b0;
            frm_inj <= 1'b0;
        end else if (accept) begin
            par_inj <= parityErrInj;
            frm_inj <= framingErrInj;
        end
    end
`else
    assign par_inj = 1'b0;
    assign frm_inj = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: table of frame configs plus hand sequences for
// back-to-back frames, mid-frame reset and (with UART_TX_ERR_INJ_EN) error injection.
// A scoreboard queue holds the expected per-cycle tx value of the frame in flight.
module tb_uart_tx_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] baudDivisor;
    logic [4:0]  overSampling;
    logic [3:0]  dataType;
    logic        parityEnable, parityType;
    logic [1:0]  stopBits;
    logic        txValid;
    logic [7:0]  txData;
    logic        parityErrInj, framingErrInj;
    logic        txReady, tx, busy, frameDone;

    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_q[$];
    int   len_q[$];
    int   cyc = 0;
    int   last_len = 0;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic [4:0]  os;
        logic [3:0]  dt;
        logic        pen;
        logic        ptype;
        logic [1:0]  stops;
        int          exp_len;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    uart_tx_serializer dut (
        .clk          (clk),
        .reset        (reset),
        .baudDivisor  (baudDivisor),
        .overSampling (overSampling),
        .dataType     (dataType),
        .parityEnable (parityEnable),
        .parityType   (parityType),
        .stopBits     (stopBits),
        .txValid      (txValid),
        .txData       (txData),
`ifdef UART_TX_ERR_INJ_EN
        .parityErrInj (parityErrInj),
        .framingErrInj(framingErrInj),
`endif
        .txReady      (txReady),
        .tx           (tx),
        .busy         (busy),
        .frameDone    (frameDone)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected frame from the current inputs, one queue entry per clk cycle.
    task automatic push_frame();
        int   nb, bc;
        logic p;
        logic bits[$];
        nb = (dataType >= 4'd5 && dataType <= 4'd8) ? int'(dataType) : 8;
        bc = ((baudDivisor == 16'd0) ? 1 : int'(baudDivisor)) * ((overSampling == 5'd13) ? 13 : 16);
        p  = parityType ^ parityErrInj;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            bits.push_back(txData[i]);
            p ^= txData[i];
        end
        if (parityEnable) bits.push_back(p);
        bits.push_back(~framingErrInj);
        if (stopBits == 2'd2) bits.push_back(1'b1);
        foreach (bits[k]) repeat (bc) exp_q.push_back(bits[k]);
        len_q.push_back(bits.size() * bc);
    endtask

    // Monitor: compare the frame in flight, then record a new accept if any.
    always @(negedge clk) begin : mon
        logic e;
        int   el;
        bit   last;
        if (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            cyc++;
            last = (exp_q.size() == 0);
            chk("tx", 32'(tx), 32'(e));
            chk("frameDone", 32'(frameDone), 32'(last));
            chk("txReady", 32'(txReady), 32'(last));
            chk("busy", 32'(busy), 32'(!last));
            if (last) begin
                el = (len_q.size() > 0) ? len_q.pop_front() : -1;
                chk("frame_len", cyc, el);
                last_len = cyc;
                cyc = 0;
            end
        end else begin
            cyc = 0;
            chk("idle_tx", 32'(tx), 1);
            chk("idle_frameDone", 32'(frameDone), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_txReady", 32'(txReady), 1);
        end
        if (!reset && txValid && txReady) push_frame();
    end

    task automatic set_cfg(input vec_t v);
        baudDivisor  = v.div;
        overSampling = v.os;
        dataType     = v.dt;
        parityEnable = v.pen;
        parityType   = v.ptype;
        stopBits     = v.stops;
    endtask

    // Raise txValid and wait (bounded) for the negedge where txReady is seen;
    // the accept happens on the following posedge.
    task automatic send(input logic [7:0] w, output bit ok, output logic fd);
        txData  = w;
        txValid = 1'b1;
        ok = 0;
        fd = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (txReady) begin
                ok = 1;
                fd = frameDone;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            if (exp_q.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("idle_timeout", 0, 1);
        #1;
    endtask

    initial begin
        bit   ok;
        logic fd;
        vecs[0] = '{8'hA5, 16'd1, 5'd16, 4'd8, 1'b0, 1'b0, 2'd1, 160};
        vecs[1] = '{8'hA5, 16'd1, 5'd16, 4'd8, 1'b1, 1'b0, 2'd1, 176};
        vecs[2] = '{8'hA5, 16'd1, 5'd16, 4'd8, 1'b1, 1'b1, 2'd1, 176};
        vecs[3] = '{8'hFF, 16'd2, 5'd13, 4'd5, 1'b0, 1'b0, 2'd2, 208};
        vecs[4] = '{8'h00, 16'd0, 5'd7,  4'd3, 1'b0, 1'b0, 2'd3, 160};
        vecs[5] = '{8'h5A, 16'd3, 5'd13, 4'd6, 1'b1, 1'b1, 2'd2, 390};
        vecs[6] = '{8'h1F, 16'd1, 5'd13, 4'd7, 1'b1, 1'b0, 2'd1, 130};

        set_cfg(vecs[0]);
        txValid       = 1'b0;
        txData        = 8'h00;
        parityErrInj  = 1'b0;
        framingErrInj = 1'b0;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", 32'(tx), 1);
        chk("reset_txReady", 32'(txReady), 1);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_frameDone", 32'(frameDone), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // table-driven frames
        for (int v = 0; v < 7; v++) begin
            set_cfg(vecs[v]);
            last_len = -1;
            send(vecs[v].data, ok, fd);
            @(posedge clk);
            #1 txValid = 1'b0;
            wait_idle(2000);
            chk($sformatf("vec%0d_len", v), last_len, vecs[v].exp_len);
        end

        // back-to-back: second word must be taken in the frameDone cycle
        set_cfg(vecs[0]);
        send(8'h55, ok, fd);
        @(posedge clk);
        #1 txData = 8'h0F;
        send(8'h0F, ok, fd);
        chk("b2b_accept_in_done", 32'(fd), 1);
        @(posedge clk);
        #1 txValid = 1'b0;
        wait_idle(2000);

        // reset in the middle of the data bits of 0x3C
        send(8'h3C, ok, fd);
        @(posedge clk);
        #1 txValid = 1'b0;
        repeat (35) @(posedge clk);
        #1;
        chk("pre_reset_tx", 32'(tx), 0);
        reset = 1'b1;
        exp_q.delete();
        len_q.delete();
        #1;
        chk("mid_reset_tx", 32'(tx), 1);
        chk("mid_reset_busy", 32'(busy), 0);
        chk("mid_reset_txReady", 32'(txReady), 1);
        chk("mid_reset_frameDone", 32'(frameDone), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // recovery frame; config is disturbed after accept and must not matter
        last_len = -1;
        send(8'h81, ok, fd);
        @(posedge clk);
        #1;
        txValid      = 1'b0;
        dataType     = 4'd5;
        parityEnable = 1'b1;
        stopBits     = 2'd2;
        baudDivisor  = 16'd3;
        wait_idle(2000);
        chk("recover_len", last_len, 160);

`ifdef UART_TX_ERR_INJ_EN
        // even parity of 0xA5 is 0, injected -> 1; framing error -> STOP1 low
        set_cfg(vecs[1]);
        parityErrInj  = 1'b1;
        framingErrInj = 1'b1;
        last_len = -1;
        send(8'hA5, ok, fd);
        @(posedge clk);
        #1;
        txValid       = 1'b0;
        parityErrInj  = 1'b0;
        framingErrInj = 1'b0;
        repeat (149) @(posedge clk);
        #1 chk("inj_parity_bit", 32'(tx), 1);
        repeat (20) @(posedge clk);
        #1 chk("inj_stop1_low", 32'(tx), 0);
        wait_idle(2000);
        chk("inj_len", last_len, 176);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
